// File: rtl/deposit_pkg.sv
// Shared types and helpers for the deposit bank: per-channel state encoding
// and the channel-select width calculation.
package deposit_pkg;

    // Per-channel override state.
    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_DEP  = 2'd1,
        CH_FRC  = 2'd2
    } ch_state_t;

    // Width of a channel index; a single channel still needs a 1-bit select.
    function automatic int calc_cw(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/deposit_cell.sv
// One channel of the deposit bank. A reg channel holds a single stored value;
// a net channel keeps the driver value separately so that q can return to it
// when a deposit is overwritten or a force is released.
module deposit_cell
    import deposit_pkg::*;
#(
    parameter int W      = 8,
    parameter bit IS_NET = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         dep_en,
    input  logic [W-1:0] dep_data,
    input  logic         frc_en,
    input  logic         rel_en,
    input  logic [W-1:0] frc_data,
    output logic [W-1:0] q,
    output logic         dep_pending,
    output logic         frc_active
);

    ch_state_t    state_q, state_d;
    logic [W-1:0] val_q, val_d;
    logic [W-1:0] drv_q, drv_d;

    // Next-state resolution: force beats release beats deposit beats write.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        drv_d   = drv_q;

        // A net's driver keeps tracking writes in every state, even when forced.
        if (IS_NET && wr_en) begin
            drv_d = wr_data;
        end else begin
            drv_d = drv_q;
        end

        if (frc_en) begin
            state_d = CH_FRC;
            val_d   = frc_data;
        end else begin
            case (state_q)
                CH_FRC: begin
                    if (rel_en) begin
                        state_d = CH_IDLE;
                        // A net snaps back to its driver; a reg keeps the forced value.
                        if (IS_NET) begin
                            val_d = drv_d;
                        end else begin
                            val_d = val_q;
                        end
                    end else begin
                        state_d = state_q;
                        val_d   = val_q;
                    end
                end
                CH_IDLE, CH_DEP: begin
                    if (dep_en) begin
                        state_d = CH_DEP;
                        val_d   = dep_data;
                    end else if (wr_en) begin
                        // A pending deposit on a net survives a write that does
                        // not change the driver value.
                        if (!IS_NET || (state_q == CH_IDLE) || (wr_data != drv_q)) begin
                            state_d = CH_IDLE;
                            val_d   = wr_data;
                        end else begin
                            state_d = state_q;
                            val_d   = val_q;
                        end
                    end else begin
                        state_d = state_q;
                        val_d   = val_q;
                    end
                end
                default: begin
                    state_d = CH_IDLE;
                    val_d   = val_q;
                end
            endcase
        end
    end

    // Channel state, visible value and driver value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_IDLE;
            val_q   <= '0;
            drv_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            drv_q   <= drv_d;
        end
    end

    assign q           = val_q;
    assign dep_pending = (state_q == CH_DEP);
    assign frc_active  = (state_q == CH_FRC);

endmodule

// File: rtl/deposit_bank.sv
// Bank of N deposit/force channels. The top only decodes the shared deposit
// and force/release requests onto per-channel strobes; all state lives in
// the per-channel cells.
module deposit_bank
    import deposit_pkg::*;
#(
    parameter int         W        = 8,
    parameter int         N        = 4,
    parameter logic [N-1:0] NET_MASK = '0,
    localparam int        CW       = calc_cw(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   wr_en,
    input  logic [N*W-1:0] wr_data,
    input  logic           dep_en,
    input  logic [CW-1:0]  dep_ch,
    input  logic [W-1:0]   dep_data,
    input  logic           frc_en,
    input  logic           rel_en,
    input  logic [CW-1:0]  frc_ch,
    input  logic [W-1:0]   frc_data,
    output logic [N*W-1:0] q,
    output logic [N-1:0]   dep_pending,
    output logic [N-1:0]   frc_active
);

    logic         dep_ok_s;
    logic         frc_ok_s;
    logic [N-1:0] dep_sel_s;
    logic [N-1:0] frc_sel_s;
    logic [N-1:0] rel_sel_s;

    // Out-of-range channel selects are dropped entirely.
    always_comb begin
        dep_ok_s = 1'b0;
        frc_ok_s = 1'b0;
        if (int'(dep_ch) < N) begin
            dep_ok_s = dep_en;
        end else begin
            dep_ok_s = 1'b0;
        end
        if (int'(frc_ch) < N) begin
            frc_ok_s = 1'b1;
        end else begin
            frc_ok_s = 1'b0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        localparam logic [CW-1:0] IDX = CW'(i);

        assign dep_sel_s[i] = dep_ok_s && (dep_ch == IDX);
        assign frc_sel_s[i] = frc_ok_s && frc_en && (frc_ch == IDX);
        assign rel_sel_s[i] = frc_ok_s && rel_en && (frc_ch == IDX);

        deposit_cell #(
            .W      (W),
            .IS_NET (NET_MASK[i])
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_en       (wr_en[i]),
            .wr_data     (wr_data[i*W +: W]),
            .dep_en      (dep_sel_s[i]),
            .dep_data    (dep_data),
            .frc_en      (frc_sel_s[i]),
            .rel_en      (rel_sel_s[i]),
            .frc_data    (frc_data),
            .q           (q[i*W +: W]),
            .dep_pending (dep_pending[i]),
            .frc_active  (frc_active[i])
        );
    end

endmodule

// File: tb/tb_deposit_bank.sv
// Self-checking bench for deposit_bank: directed scenarios followed by
// randomized traffic compared against a behavioural per-channel model.
module tb_deposit_bank;

    localparam int         W  = 8;
    localparam int         N  = 4;
    localparam int         CW = 2;
    localparam logic [3:0] NM = 4'b0010;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   wr_en;
    logic [N*W-1:0] wr_data;
    logic           dep_en;
    logic [CW-1:0]  dep_ch;
    logic [W-1:0]   dep_data;
    logic           frc_en;
    logic           rel_en;
    logic [CW-1:0]  frc_ch;
    logic [W-1:0]   frc_data;
    logic [N*W-1:0] q;
    logic [N-1:0]   dep_pending;
    logic [N-1:0]   frc_active;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 = idle, 1 = deposit pending, 2 = forced.
    int       m_st  [N];
    logic [7:0] m_q [N];
    logic [7:0] m_drv[N];

    deposit_bank #(.W(W), .N(N), .NET_MASK(NM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .dep_en      (dep_en),
        .dep_ch      (dep_ch),
        .dep_data    (dep_data),
        .frc_en      (frc_en),
        .rel_en      (rel_en),
        .frc_ch      (frc_ch),
        .frc_data    (frc_data),
        .q           (q),
        .dep_pending (dep_pending),
        .frc_active  (frc_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] lane(input int ch, input logic [7:0] v);
        logic [N*W-1:0] r;
        r = '0;
        r[ch*W +: W] = v;
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_st[c]  = 0;
            m_q[c]   = 8'h00;
            m_drv[c] = 8'h00;
        end
    endtask

    // Apply the behavioural rules for one clock edge using the current inputs.
    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            bit         net;
            bit         we, de, fe, re;
            logic [7:0] wd, old_drv;
            net     = NM[c];
            we      = wr_en[c];
            wd      = wr_data[c*W +: W];
            de      = dep_en && (int'(dep_ch) == c);
            fe      = frc_en && (int'(frc_ch) == c);
            re      = rel_en && (int'(frc_ch) == c);
            old_drv = m_drv[c];
            if (net && we) m_drv[c] = wd;
            if (fe) begin
                m_st[c] = 2;
                m_q[c]  = frc_data;
            end else if (m_st[c] == 2) begin
                if (re) begin
                    m_st[c] = 0;
                    if (net) m_q[c] = m_drv[c];
                end
            end else if (de) begin
                m_st[c] = 1;
                m_q[c]  = dep_data;
            end else if (we) begin
                if (!net || m_st[c] == 0 || wd != old_drv) begin
                    m_st[c] = 0;
                    m_q[c]  = wd;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [N*W-1:0] eq;
        logic [N-1:0]   ed, ef;
        for (int c = 0; c < N; c++) begin
            eq[c*W +: W] = m_q[c];
            ed[c]        = (m_st[c] == 1);
            ef[c]        = (m_st[c] == 2);
        end
        check_eq({tag, "_q"},   64'(q),           64'(eq));
        check_eq({tag, "_dep"}, 64'(dep_pending), 64'(ed));
        check_eq({tag, "_frc"}, 64'(frc_active),  64'(ef));
    endtask

    task automatic idle_inputs();
        wr_en    = '0;
        wr_data  = '0;
        dep_en   = 1'b0;
        dep_ch   = '0;
        dep_data = '0;
        frc_en   = 1'b0;
        rel_en   = 1'b0;
        frc_ch   = '0;
        frc_data = '0;
    endtask

    // Inputs are already set; advance one edge and compare with the model.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_model("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Reg ch0 deposit, then a same-value write clears the pending flag.
        dep_en = 1'b1; dep_ch = 2'd0; dep_data = 8'hA5;
        step("r30a");
        check_eq("r30a_q0", 64'(q[7:0]), 64'h A5);
        check_eq("r30a_dp0", 64'(dep_pending[0]), 64'h1);
        wr_en = 4'b0001; wr_data = lane(0, 8'hA5);
        step("r30b");
        check_eq("r30b_dp0", 64'(dep_pending[0]), 64'h0);

        // Net ch1 deposit survives an unchanged driver write.
        wr_en = 4'b0010; wr_data = lane(1, 8'h11);
        step("r31a");
        dep_en = 1'b1; dep_ch = 2'd1; dep_data = 8'h77;
        step("r31b");
        check_eq("r31b_q1", 64'(q[15:8]), 64'h77);
        wr_en = 4'b0010; wr_data = lane(1, 8'h11);
        step("r31c");
        check_eq("r31c_q1", 64'(q[15:8]), 64'h77);
        wr_en = 4'b0010; wr_data = lane(1, 8'h22);
        step("r31d");
        check_eq("r31d_q1", 64'(q[15:8]), 64'h22);
        check_eq("r31d_dp1", 64'(dep_pending[1]), 64'h0);

        // Reg ch2 force, write ignored, release keeps forced value.
        frc_en = 1'b1; frc_ch = 2'd2; frc_data = 8'h3C;
        step("r32a");
        wr_en = 4'b0100; wr_data = lane(2, 8'hFF);
        step("r32b");
        check_eq("r32b_q2", 64'(q[23:16]), 64'h3C);
        rel_en = 1'b1; frc_ch = 2'd2;
        step("r32c");
        check_eq("r32c_q2", 64'(q[23:16]), 64'h3C);
        wr_en = 4'b0100; wr_data = lane(2, 8'h01);
        step("r32d");
        check_eq("r32d_q2", 64'(q[23:16]), 64'h01);

        // Net ch1 force; release snaps to the driver written meanwhile.
        frc_en = 1'b1; frc_ch = 2'd1; frc_data = 8'h3C;
        step("r33a");
        wr_en = 4'b0010; wr_data = lane(1, 8'h55);
        step("r33b");
        check_eq("r33b_q1", 64'(q[15:8]), 64'h3C);
        rel_en = 1'b1; frc_ch = 2'd1;
        step("r33c");
        check_eq("r33c_q1", 64'(q[15:8]), 64'h55);

        // Same-cycle force, deposit and write on ch3.
        frc_en = 1'b1; frc_ch = 2'd3; frc_data = 8'h0F;
        dep_en = 1'b1; dep_ch = 2'd3; dep_data = 8'hF0;
        wr_en = 4'b1000; wr_data = lane(3, 8'hAA);
        step("r34");
        check_eq("r34_q3", 64'(q[31:24]), 64'h0F);
        check_eq("r34_fa3", 64'(frc_active[3]), 64'h1);
        check_eq("r34_dp3", 64'(dep_pending[3]), 64'h0);

        // Release on a channel that is not forced does nothing.
        rel_en = 1'b1; frc_ch = 2'd0;
        step("r23");

        // Force ch0 then reset asynchronously between edges.
        frc_en = 1'b1; frc_ch = 2'd0; frc_data = 8'h99;
        step("r35a");
        check_eq("r35a_q0", 64'(q[7:0]), 64'h99);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("r35_q", 64'(q), 64'h0);
        check_eq("r35_frc", 64'(frc_active), 64'h0);
        check_eq("r35_dep", 64'(dep_pending), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_model("post_reset");

        // Randomized traffic with a narrow data range to hit equal-driver writes.
        for (int k = 0; k < 400; k++) begin
            wr_en = 4'($urandom_range(0, 15));
            for (int c = 0; c < N; c++) begin
                wr_data[c*W +: W] = 8'($urandom_range(0, 3));
            end
            dep_en   = ($urandom_range(0, 3) == 0);
            dep_ch   = 2'($urandom_range(0, 3));
            dep_data = 8'($urandom_range(0, 255));
            frc_en   = ($urandom_range(0, 7) == 0);
            rel_en   = ($urandom_range(0, 3) == 0);
            frc_ch   = 2'($urandom_range(0, 3));
            frc_data = 8'($urandom_range(0, 255));
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/deposit_bank.md
DEPOSIT_BANK -- requirements
Module: deposit_bank

Interface
REQ-001 SHALL have parameter W, default 8, data width per channel (1..64).
REQ-002 SHALL have parameter N, default 4, channel count (1..32).
REQ-003 SHALL have parameter NET_MASK, default '0, N bits; bit i=1 gives channel i net semantics, 0 gives reg semantics.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_en  input  N  per-channel normal write (driver update) strobe.
REQ-007 SHALL have port wr_data  input  N*W  per-channel write data; channel i in bits [i*W +: W].
REQ-008 SHALL have port dep_en, dep_ch, dep_data  input  1 / CW / W  one-shot deposit request; CW = max(1,$clog2(N)).
REQ-009 SHALL have port frc_en, rel_en, frc_ch, frc_data  input  1 / 1 / CW / W  force and release requests.
REQ-010 SHALL have port q  output  N*W  registered visible channel values.
REQ-011 SHALL have ports dep_pending, frc_active  output  N / N  per-channel status flags.

Function
REQ-012 SHALL keep per channel: state {CH_IDLE, CH_DEP, CH_FRC}, stored value (reg) or driver value plus override value (net).
REQ-013 SHALL make every effect visible on q and flags the cycle after the sampling edge (latency 1).
REQ-014 Reg channel, CH_IDLE/CH_DEP: wr_en loads wr_data into q, state -> CH_IDLE.
REQ-015 Reg channel: dep_en loads dep_data into q, state -> CH_DEP; held until next wr_en regardless of wr_data value.
REQ-016 Net channel: wr_en always updates driver value; q follows driver value in CH_IDLE.
REQ-017 Net channel: dep_en sets q=dep_data, state -> CH_DEP; cleared (q=driver, CH_IDLE) only by wr_en whose wr_data differs from current driver value.
REQ-018 Any channel: frc_en sets q=frc_data, state -> CH_FRC; further frc_en in CH_FRC updates the forced value.
REQ-019 Reg channel in CH_FRC: wr_en and dep_en ignored; rel_en -> CH_IDLE, q keeps forced value.
REQ-020 Net channel in CH_FRC: wr_en still updates driver value, dep_en ignored; rel_en -> CH_IDLE, q = driver value.
REQ-021 Same-cycle same-channel priority: frc_en > rel_en > dep_en > wr_en; losing dep_en/rel_en dropped silently.
REQ-022 dep_en together with wr_en on same channel: deposit wins on q; net driver value still updated.
REQ-023 rel_en on channel not in CH_FRC SHALL be a no-op.
REQ-024 dep_ch/frc_ch >= N SHALL be ignored with no state change.
REQ-025 dep_pending[i] = (state==CH_DEP); frc_active[i] = (state==CH_FRC).

Reset
REQ-026 rst_n low SHALL asynchronously clear q, driver values, dep_pending, frc_active to 0 and all states to CH_IDLE, including mid-force or mid-deposit.
REQ-027 SHALL resume normal operation on first rising clk edge after rst_n deasserts.

Structure
REQ-028 Package deposit_pkg SHALL hold ch_state_t enum and CW width function.
REQ-029 Sub-module deposit_cell SHALL implement one channel (parameters W, IS_NET), generated N times; top only decodes dep_ch/frc_ch.

Verification (W=8, N=4, NET_MASK=4'b0010)
REQ-030 Reg ch0: deposit 0xA5 -> q0=0xA5, dep_pending[0]=1; then wr 0xA5 -> q0=0xA5, dep_pending[0]=0.
REQ-031 Net ch1: wr 0x11, deposit 0x77 -> q1=0x77; wr 0x11 -> q1 stays 0x77; wr 0x22 -> q1=0x22, dep_pending[1]=0.
REQ-032 Reg ch2: force 0x3C, wr 0xFF -> q2=0x3C; release -> q2=0x3C; wr 0x01 -> q2=0x01.
REQ-033 Net ch1: force 0x3C, wr 0x55 -> q1=0x3C; release -> q1=0x55.
REQ-034 Same cycle ch3: frc_en 0x0F + dep_en 0xF0 + wr 0xAA -> q3=0x0F, frc_active[3]=1, dep_pending[3]=0.
REQ-035 Force ch0 0x99, then rst_n low mid-cycle -> q=0 and frc_active=0 immediately, before next clk edge.
